// File: rtl/alu_md_controller.sv
// alu_md_controller: ALU op decode plus iterative RV32M multiply/divide sequencer
module alu_md_controller #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      ALU_Op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic            valid_in,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [3:0]      op,
  output logic            md_sel,
  output logic            stall,
  output logic            md_done,
  output logic [XLEN-1:0] md_result
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] hi, lo, m, ma, mb, spec_res, r_nxt, q_nxt, quo, rem, fin;
  logic [XLEN:0] sum, t;
  logic [2*XLEN-1:0] p_nxt, prod;
  logic [3:0] alu_op;
  logic [2:0] f3;
  logic sa, sb, req, sa_in, sb_in, dz, ovf, special;
  always_comb begin
    md_sel = ALU_Op == 2'b10 && funct7 == 7'b0000001;
    case (funct3)
      3'd0: alu_op = (ALU_Op == 2'b10 && funct7[5]) ? 4'd1 : 4'd0;
      3'd1: alu_op = 4'd2;
      3'd2: alu_op = 4'd3;
      3'd3: alu_op = 4'd4;
      3'd4: alu_op = 4'd5;
      3'd5: alu_op = funct7[5] ? 4'd7 : 4'd6;
      3'd6: alu_op = 4'd8;
      default: alu_op = 4'd9;
    endcase
    op = md_sel ? 4'd15 : ALU_Op[1] ? alu_op : {3'b000, ALU_Op[0]};
  end
  always_comb begin
    req = valid_in && md_sel;
    sa_in = a[XLEN-1] && (funct3[2] ? !funct3[0] : funct3 != 3'd3);
    sb_in = b[XLEN-1] && (funct3[2] ? !funct3[0] : !funct3[1]);
    dz = b == '0;
    ovf = !funct3[0] && a == {1'b1, {(XLEN-1){1'b0}}} && &b;
    special = funct3[2] && (dz || ovf);
    spec_res = dz ? (funct3[1] ? a : '1) : (funct3[1] ? '0 : a);
    ma = sa_in ? -a : a;
    mb = sb_in ? -b : b;
    sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    p_nxt = {sum, lo[XLEN-1:1]};
    t = {hi, lo[XLEN-1]} - {1'b0, m};
    r_nxt = t[XLEN] ? {hi[XLEN-2:0], lo[XLEN-1]} : t[XLEN-1:0];
    q_nxt = {lo[XLEN-2:0], !t[XLEN]};
    prod = (sa ^ sb) ? -p_nxt : p_nxt;
    quo = (sa ^ sb) ? -q_nxt : q_nxt;
    rem = sa ? -r_nxt : r_nxt;
    fin = f3[2] ? (f3[1] ? rem : quo) : (f3 == 3'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    nxt = state == IDLE ? (req ? (special ? DONE : CALC) : IDLE) :
          state == CALC ? (!valid_in ? IDLE : cnt == '0 ? DONE : CALC) : IDLE;
    stall = req && state != DONE;
    md_done = state == DONE;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      md_result <= '0;
      hi <= '0;
      lo <= '0;
      m <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      f3 <= '0;
    end else if (state == IDLE && req) begin
      hi <= '0;
      lo <= funct3[2] ? ma : mb;
      m <= funct3[2] ? mb : ma;
      sa <= sa_in;
      sb <= sb_in;
      f3 <= funct3;
      cnt <= CW'(XLEN-1);
      if (special) md_result <= spec_res;
    end else if (state == CALC) begin
      hi <= f3[2] ? r_nxt : p_nxt[2*XLEN-1:XLEN];
      lo <= f3[2] ? q_nxt : p_nxt[XLEN-1:0];
      cnt <= cnt - CW'(1);
      if (valid_in && cnt == '0) md_result <= fin;
    end
  end
endmodule

// File: tb/tb_alu_md_controller.sv
// tb_alu_md_controller: scoreboard bench for decode and M-extension sequencing
module tb_alu_md_controller;
  localparam int XLEN = 32;
  logic clk = 0, rst = 1, valid_in = 0;
  logic [1:0] ALU_Op = 0;
  logic [2:0] funct3 = 0;
  logic [6:0] funct7 = 0;
  logic [XLEN-1:0] a = 0, b = 0, md_result;
  logic [3:0] op;
  logic md_sel, stall, md_done;
  int vectors = 0, miscompares = 0;
  logic [XLEN-1:0] exp_q[$];
  int lat_q[$];
  always #5 clk = ~clk;
  alu_md_controller #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .ALU_Op(ALU_Op), .funct3(funct3), .funct7(funct7),
    .valid_in(valid_in), .a(a), .b(b), .op(op), .md_sel(md_sel), .stall(stall),
    .md_done(md_done), .md_result(md_result)
  );
  function automatic logic [31:0] md_model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] sx, ux, sy, uy, p;
    logic signed [31:0] xs, ys, r;
    sx = {{32{x[31]}}, x};
    ux = {32'd0, x};
    sy = {{32{y[31]}}, y};
    uy = {32'd0, y};
    p = (f == 3'd3 ? ux : sx) * ((f == 3'd0 || f == 3'd1) ? sy : uy);
    xs = x;
    ys = y;
    case (f)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: begin
        if (y == 0) return 32'hFFFFFFFF;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return x;
        r = xs / ys;
        return r;
      end
      3'd5: return y == 0 ? 32'hFFFFFFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 0;
        r = xs % ys;
        return r;
      end
      default: return y == 0 ? x : x % y;
    endcase
  endfunction
  task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input bit push);
    ALU_Op = 2'b10;
    funct7 = 7'b0000001;
    funct3 = f;
    a = x;
    b = y;
    valid_in = 1;
    if (push) begin
      exp_q.push_back(md_model(f, x, y));
      lat_q.push_back((f[2] && (y == 0 || (!f[0] && x == 32'h80000000 && y == 32'hFFFFFFFF))) ? 2 : XLEN + 2);
    end
  endtask
  task automatic wait_done(output logic [31:0] got, output int n, output int st, output bit to);
    n = 0;
    st = 0;
    to = 1;
    got = 'x;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (stall) st++;
      if (md_done) begin
        got = md_result;
        to = 0;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    issue(3'd4, 32'd5, 32'd0, 0);
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (md_done !== 1'b0 || md_result !== 0 || stall !== 1'b1) begin
        miscompares++;
        $display("FAIL reset: done=%b result=%h stall=%b, want 0/0/1", md_done, md_result, stall);
      end
    end
    @(posedge clk);
    #1;
    rst = 0;
    valid_in = 0;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (md_done !== 1'b0 || stall !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_release: done=%b stall=%b, want 0/0", md_done, stall);
      end
    end
  endtask
  task automatic test_decode;
    logic [3:0] e;
    logic md;
    for (int o = 0; o < 4; o++)
      for (int f = 0; f < 8; f++)
        for (int g = 0; g < 128; g++) begin
          @(posedge clk);
          #1;
          ALU_Op = o[1:0];
          funct3 = f[2:0];
          funct7 = g[6:0];
          md = o == 2 && g == 1;
          valid_in = !md;
          case (f)
            0: e = (o == 2 && g[5]) ? 4'd1 : 4'd0;
            1: e = 4'd2;
            2: e = 4'd3;
            3: e = 4'd4;
            4: e = 4'd5;
            5: e = g[5] ? 4'd7 : 4'd6;
            6: e = 4'd8;
            default: e = 4'd9;
          endcase
          if (o == 0) e = 4'd0;
          if (o == 1) e = 4'd1;
          if (md) e = 4'd15;
          @(negedge clk);
          vectors++;
          if (op !== e || md_sel !== md || stall !== 1'b0 || md_done !== 1'b0) begin
            miscompares++;
            $display("FAIL decode %0d/%0d/%0d: op=%0d md_sel=%b stall=%b, want %0d/%b/0", o, f, g, op, md_sel, stall, e, md);
          end
        end
    @(posedge clk);
    #1;
    valid_in = 0;
  endtask
  task automatic test_mul;
    logic [2:0] fs [4];
    logic [31:0] xs [4], ys [4], got, e;
    int n, st, l;
    bit to;
    fs = '{3'd0, 3'd3, 3'd1, 3'd1};
    xs = '{32'd7, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    ys = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    for (int i = 0; i < 4; i++) begin
      issue(fs[i], xs[i], ys[i], 1);
      wait_done(got, n, st, to);
      e = exp_q.pop_front();
      l = lat_q.pop_front();
      vectors++;
      if (to || got !== e) begin
        miscompares++;
        $display("FAIL mul[%0d] result: got %h want %h", i, got, e);
      end
      vectors++;
      if (n !== l || st !== l - 1) begin
        miscompares++;
        $display("FAIL mul[%0d] timing: done %0d stall %0d, want %0d/%0d", i, n, st, l, l - 1);
      end
      if (i == 0) begin
        valid_in = 0;
        @(negedge clk);
        vectors++;
        if (md_done !== 1'b0 || md_result !== e) begin
          miscompares++;
          $display("FAIL mul hold: done=%b result=%h, want 0/%h", md_done, md_result, e);
        end
        @(posedge clk);
        #1;
      end
    end
  endtask
  task automatic test_div;
    logic [2:0] fs [5];
    logic [31:0] xs [5], ys [5], got, e;
    int n, st, l;
    bit to;
    fs = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd5};
    xs = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'h80000000};
    ys = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFF};
    for (int i = 0; i < 5; i++) begin
      issue(fs[i], xs[i], ys[i], 1);
      wait_done(got, n, st, to);
      e = exp_q.pop_front();
      l = lat_q.pop_front();
      vectors++;
      if (to || got !== e) begin
        miscompares++;
        $display("FAIL div[%0d] result: got %h want %h", i, got, e);
      end
      vectors++;
      if (n !== l || st !== l - 1) begin
        miscompares++;
        $display("FAIL div[%0d] timing: done %0d stall %0d, want %0d/%0d", i, n, st, l, l - 1);
      end
    end
  endtask
  task automatic test_special;
    logic [2:0] fs [6];
    logic [31:0] xs [6], ys [6], got, e;
    int n, st, l;
    bit to;
    fs = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
    xs = '{32'd5, 32'd5, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
    ys = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    for (int i = 0; i < 6; i++) begin
      issue(fs[i], xs[i], ys[i], 1);
      wait_done(got, n, st, to);
      e = exp_q.pop_front();
      l = lat_q.pop_front();
      vectors++;
      if (to || got !== e) begin
        miscompares++;
        $display("FAIL special[%0d] result: got %h want %h", i, got, e);
      end
      vectors++;
      if (n !== l || st !== l - 1) begin
        miscompares++;
        $display("FAIL special[%0d] timing: done %0d stall %0d, want %0d/%0d", i, n, st, l, l - 1);
      end
    end
  endtask
  task automatic test_abort;
    logic [31:0] got, e, held;
    int n, st, l;
    bit to;
    held = md_result;
    issue(3'd4, 32'd1000, 32'd3, 0);
    repeat (10) @(posedge clk);
    #1;
    valid_in = 0;
    @(negedge clk);
    vectors++;
    if (md_done !== 1'b0 || stall !== 1'b0 || md_result !== held) begin
      miscompares++;
      $display("FAIL abort: done=%b stall=%b result=%h, want 0/0/%h", md_done, stall, md_result, held);
    end
    @(posedge clk);
    #1;
    issue(3'd2, 32'hFFFFFFFF, 32'd2, 1);
    wait_done(got, n, st, to);
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    vectors++;
    if (to || got !== e) begin
      miscompares++;
      $display("FAIL abort_next result: got %h want %h", got, e);
    end
    vectors++;
    if (n !== l || st !== l - 1) begin
      miscompares++;
      $display("FAIL abort_next timing: done %0d stall %0d, want %0d/%0d", n, st, l, l - 1);
    end
  endtask
  task automatic test_reset_mid;
    logic [31:0] got, e;
    int n, st, l;
    bit to;
    issue(3'd0, 32'd6, 32'd7, 0);
    repeat (6) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    valid_in = 0;
    @(negedge clk);
    vectors++;
    if (md_done !== 1'b0 || md_result !== 0 || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: done=%b result=%h stall=%b, want 0/0/0", md_done, md_result, stall);
    end
    @(posedge clk);
    #1;
    issue(3'd0, 32'd3, 32'd4, 1);
    wait_done(got, n, st, to);
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    vectors++;
    if (to || got !== e) begin
      miscompares++;
      $display("FAIL reset_mid_next result: got %h want %h", got, e);
    end
    vectors++;
    if (n !== l || st !== l - 1) begin
      miscompares++;
      $display("FAIL reset_mid_next timing: done %0d stall %0d, want %0d/%0d", n, st, l, l - 1);
    end
  endtask
  task automatic test_back_to_back;
    logic [31:0] got, e, x, y;
    logic [2:0] f;
    int n, st, l;
    bit to;
    for (int i = 0; i < 16; i++) begin
      f = 3'($urandom_range(0, 7));
      x = $urandom;
      y = (i % 5 == 3) ? 32'd0 : (i % 4 == 1) ? 32'($urandom_range(1, 300)) : $urandom;
      issue(f, x, y, 1);
      wait_done(got, n, st, to);
      e = exp_q.pop_front();
      l = lat_q.pop_front();
      vectors++;
      if (to || got !== e) begin
        miscompares++;
        $display("FAIL b2b[%0d] f3=%0d a=%h b=%h: got %h want %h", i, f, x, y, got, e);
      end
      vectors++;
      if (n !== l || st !== l - 1) begin
        miscompares++;
        $display("FAIL b2b[%0d] timing: done %0d stall %0d, want %0d/%0d", i, n, st, l, l - 1);
      end
    end
    valid_in = 0;
  endtask
  initial begin
    test_reset;
    test_decode;
    test_mul;
    test_div;
    test_special;
    test_abort;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_md_controller.md
# alu_md_controller

Parametrised successor to the base ALU controller. It decodes `ALU_Op`/`funct3`/`funct7` into the 4-bit ALU operation code. It also sequences an iterative RV32M multiply/divide datapath that stalls the execute stage until the result is ready. It sits in the execute stage beside the ALU. The core mux selects `md_result` instead of the ALU output when `md_sel` is high.

## Interface
- `XLEN`, 32: operand/result width; iteration count for multiply and divide.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `ALU_Op` input 2: 00 = add (load/store), 01 = sub (branch), 10 = R-type, 11 = I-type ALU.
- `funct3` input 3: instruction funct3.
- `funct7` input 7: instruction funct7.
- `valid_in` input 1: the execute stage holds a live instruction.
- `a`, `b` input XLEN each: rs1 and rs2 operand values.
- `op` output 4: ALU code; combinational.
- `md_sel` output 1: the instruction is RV32M; combinational.
- `stall` output 1: holds the pipeline; combinational.
- `md_done` output 1: `md_result` is valid in this cycle; registered.
- `md_result` output XLEN: M-extension result; registered.

## Operation
- `op` codes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 15 MD.
- Decode for `ALU_Op` 00 and 01: 00 gives ADD; 01 gives SUB.
- Decode for `ALU_Op` 10 or 11: `funct3` selects the operation.
- SUB applies only when `ALU_Op`=10 and `funct7[5]`=1 and `funct3`=000.
- SRA applies when `funct7[5]`=1 and `funct3`=101.
- Unused codes decode to ADD.
- `md_sel` = (`ALU_Op`==10 && `funct7`==0000001). When `md_sel` is high, `op`=15.
- M-extension `funct3`: 0 MUL (low XLEN bits), 1 MULH (s×s, high), 2 MULHSU (s×u, high), 3 MULHU (u×u, high), 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- Signed operations work on magnitudes. The sign is applied in the final cycle: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
- Multiply is shift-add over a 2·XLEN accumulator.
- Divide is restoring division, one quotient bit per cycle.
- FSM states: IDLE, CALC, DONE.
  - IDLE→CALC when `valid_in && md_sel` and no special case applies. Operands, sign flags and funct3 are captured; the iteration counter loads XLEN-1.
  - IDLE→DONE directly on a divide special case.
  - CALC stays while the counter is nonzero, decrementing each cycle. CALC→DONE when the counter reaches 0, and the result is registered on that edge.
  - CALC→IDLE (abort) if `valid_in` falls. `md_done` is not asserted.
  - DONE→IDLE unconditionally after one cycle.
- Divide special cases (latency 1, no CALC):
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (−2^(XLEN−1) ÷ −1): quotient = dividend; remainder = 0.
- `stall` = `valid_in && md_sel && state!=DONE`.
- `md_done` = (state==DONE).
- `md_result` holds its last value outside DONE.

## Timing
- Reset: state = IDLE; `md_done`=0; `md_result`=0; counter=0. `stall` is then 0 unless `valid_in && md_sel` is asserted in the same cycle.
- An instruction accepted at edge T (IDLE sampled) spends T+1..T+XLEN in CALC. DONE occurs in cycle T+XLEN+1, so normal latency = XLEN+1 cycles.
- Special-case latency: DONE in cycle T+1.
- The pipeline advances at the end of the DONE cycle, because `stall` is low there.
- A back-to-back M instruction is accepted on the next edge in IDLE. The minimum accept spacing is XLEN+2 cycles, or 2 cycles for special cases.
- `rst` asserted during CALC or DONE returns to IDLE on the next edge. `md_done` is low from then on, and the partial result is discarded.
- Non-M instructions never stall and never touch the FSM.
- Simultaneous `rst` and a new request: reset wins; the request is not captured.

## Test plan
- Decode sweep over all `ALU_Op`/funct3/funct7 combinations. Examples: (10,000,0100000)→`op`=1; (11,101,0100000)→7; (01,xxx,x)→1; (10,xxx,0000001)→15 with `md_sel`=1.
- MUL a=7, b=−3: `stall` high for 33 cycles; `md_done` in cycle T+33 with `md_result`=0xFFFFFFEB. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV −7÷2 → 0xFFFFFFFD; REM −7÷2 → 0xFFFFFFFF; DIVU 100÷7 → 14; REMU 100÷7 → 2.
- DIV 5÷0 → 0xFFFFFFFF and REM 5÷0 → 5, both with `md_done` at T+1. DIV 0x80000000÷−1 → 0x80000000; REM of the same → 0.
- Abort: drop `valid_in` at cycle T+10 of a DIV. The FSM is in IDLE at T+11, and `md_done` never pulses. A new MULHSU (−1×2 → 0xFFFFFFFF) then completes normally.
- Assert `rst` for one cycle mid-CALC. Next cycle: `md_done`=0, `md_result`=0, state IDLE. A following MUL 3×4 returns 12.
